scariv_ftq_mq: RTL

Multi-port, parametrised Fetch Target Queue that records in-flight branches in program order and returns their resolved outcomes to the frontend predictors in order. It sits between dispatch, the branch units and the frontend. Per cycle it can allocate up to ALLOC_W branches and accept UPD_PORTS resolutions. On a mispredict it squashes only the younger entries, instead of flushing the whole queue. The frontend output uses a valid/ready handshake.

---
 rtl/scariv_ftq_mq_pkg.sv | 51 +++++
 rtl/scariv_ftq_oldest_sel.sv | 43 ++++
 rtl/scariv_ftq_mq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/scariv_ftq_mq_pkg.sv
// Shared types for the multi-port fetch target queue: allocation, resolution,
// frontend-output payloads and the internal per-entry record.
package scariv_pkg;

    localparam int VADDR_W   = 39;
    localparam int CMT_ID_W  = 8;
    localparam int GRP_ID_W  = 4;
    localparam int RAS_W     = 4;
    localparam int GSHARE_W  = 10;
    localparam int FTQ_DEPTH = 16;
    localparam int FTQ_IDX_W = $clog2(FTQ_DEPTH);

    typedef struct packed {
        logic [CMT_ID_W-1:0] cmt_id;
        logic [GRP_ID_W-1:0] grp_id;
        logic [VADDR_W-1:0]  pc_vaddr;
        logic                is_call;
        logic                is_ret;
        logic                is_rvc;
        logic [RAS_W-1:0]    ras_index;
        logic [1:0]          bim_value;
        logic [GSHARE_W-1:0] gshare_index;
        logic [GSHARE_W-1:0] gshare_bhr;
    } ftq_alloc_t;

    typedef struct packed {
        logic [FTQ_IDX_W-1:0] idx;
        logic                 is_cond;
        logic                 taken;
        logic                 mispredict;
        logic                 dead;
        logic [VADDR_W-1:0]   target_vaddr;
    } ftq_upd_t;

    typedef struct packed {
        ftq_alloc_t         info;
        logic               is_cond;
        logic               taken;
        logic               mispredict;
        logic [VADDR_W-1:0] target_vaddr;
    } ftq_out_t;

    typedef struct packed {
        logic     valid;
        logic     done;
        logic     notify;
        logic     dead;
        ftq_out_t data;
    } ftq_mq_entry_t;

endpackage

// File: rtl/scariv_ftq_oldest_sel.sv
// Picks the mispredict candidate closest to the queue head (smallest age);
// ties on the same index resolve to the lowest port.
module scariv_ftq_oldest_sel #(
    parameter int UPD_PORTS = 2,
    parameter int IDX_W     = 4
) (
    input  logic [UPD_PORTS-1:0]            cand_i,
    input  logic [UPD_PORTS-1:0][IDX_W-1:0] idx_i,
    input  logic [IDX_W-1:0]                head_i,
    output logic [UPD_PORTS-1:0]            oldest_oh_o,
    output logic [IDX_W-1:0]                oldest_age_o
);

    logic [UPD_PORTS-1:0][IDX_W-1:0] age_s;
    logic [UPD_PORTS-1:0]            win_s;

    // Age compare across all candidate pairs.
    always_comb begin
        oldest_oh_o  = '0;
        oldest_age_o = '0;
        for (int p = 0; p < UPD_PORTS; p++) begin
            age_s[p] = idx_i[p] - head_i;
        end
        for (int p = 0; p < UPD_PORTS; p++) begin
            win_s[p] = cand_i[p];
            for (int q = 0; q < UPD_PORTS; q++) begin
                if ((q != p) && cand_i[q] &&
                    ((age_s[q] < age_s[p]) || ((age_s[q] == age_s[p]) && (q < p)))) begin
                    win_s[p] = 1'b0;
                end else begin
                    win_s[p] = win_s[p];
                end
            end
            oldest_oh_o[p] = win_s[p];
            if (win_s[p]) begin
                oldest_age_o = age_s[p];
            end else begin
                oldest_age_o = oldest_age_o;
            end
        end
    end

endmodule

// File: rtl/scariv_ftq_mq.sv
// Fetch target queue: in-order branch records, multi-port resolution,
// partial squash on mispredict and in-order drain to the frontend predictors.
module scariv_ftq_mq
    import scariv_pkg::*;
#(
    parameter int DEPTH     = FTQ_DEPTH,
    parameter int ALLOC_W   = 2,
    parameter int UPD_PORTS = 2,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [ALLOC_W-1:0]            i_alloc_valid,
    input  ftq_alloc_t [ALLOC_W-1:0]      i_alloc_info,
    output logic                          o_alloc_ready,
    output logic [ALLOC_W-1:0][IDX_W-1:0] o_alloc_idx,
    input  logic [UPD_PORTS-1:0]          i_upd_valid,
    input  ftq_upd_t [UPD_PORTS-1:0]      i_upd_info,
    input  logic                          i_commit_flush,
    output logic                          o_fe_valid,
    output ftq_out_t                      o_fe_info,
    input  logic                          i_fe_ready,
    output logic                          o_empty,
    output logic [IDX_W:0]                o_count
);

    ftq_mq_entry_t entry_q [DEPTH];
    ftq_mq_entry_t entry_d [DEPTH];
    logic [IDX_W:0] head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0] count_s, free_s, alloc_cnt_s;
    logic [IDX_W-1:0] head_lo_s, rb_age_s, ent_age_s;
    logic [UPD_PORTS-1:0][IDX_W-1:0] upd_idx_s, upd_age_s;
    logic [UPD_PORTS-1:0] misp_cand_s, rb_oh_s;
    logic rb_valid_s, any_misp_s, alloc_fire_s, retire_s;
    ftq_mq_entry_t head_e_s;

    assign head_lo_s  = head_q[IDX_W-1:0];
    assign count_s    = tail_q - head_q;
    assign free_s     = (IDX_W+1)'(DEPTH) - count_s;
    assign head_e_s   = entry_q[head_lo_s];
    assign any_misp_s = |misp_cand_s;
    assign rb_valid_s = |rb_oh_s;

    assign o_alloc_ready = (free_s >= (IDX_W+1)'(ALLOC_W)) & ~i_commit_flush & ~any_misp_s;
    assign alloc_fire_s  = o_alloc_ready & (|i_alloc_valid);
    assign o_fe_valid    = head_e_s.valid & head_e_s.done & head_e_s.notify;
    assign o_fe_info     = head_e_s.data;
    assign o_empty       = (head_q == tail_q);
    assign o_count       = count_s;
    // Dead branches leave silently; live ones need the frontend handshake.
    assign retire_s = head_e_s.valid & head_e_s.done &
                      (head_e_s.dead | (head_e_s.notify & i_fe_ready));

    // Per-port index, age and mispredict candidacy.
    always_comb begin
        for (int p = 0; p < UPD_PORTS; p++) begin
            upd_idx_s[p]   = IDX_W'(i_upd_info[p].idx);
            upd_age_s[p]   = upd_idx_s[p] - head_lo_s;
            misp_cand_s[p] = i_upd_valid[p] & i_upd_info[p].mispredict;
        end
    end

    // Allocation indices and popcount of the contiguous request mask.
    always_comb begin
        alloc_cnt_s = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            o_alloc_idx[k] = tail_q[IDX_W-1:0] + IDX_W'(k);
            alloc_cnt_s    = alloc_cnt_s + (IDX_W+1)'(i_alloc_valid[k]);
        end
    end

    scariv_ftq_oldest_sel #(
        .UPD_PORTS (UPD_PORTS),
        .IDX_W     (IDX_W)
    ) u_oldest_sel (
        .cand_i       (misp_cand_s),
        .idx_i        (upd_idx_s),
        .head_i       (head_lo_s),
        .oldest_oh_o  (rb_oh_s),
        .oldest_age_o (rb_age_s)
    );

    // Next-state: allocate, resolve, squash, retire, then flush overrides all.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        ent_age_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (alloc_fire_s) begin
            for (int k = 0; k < ALLOC_W; k++) begin
                if (i_alloc_valid[k]) begin
                    entry_d[o_alloc_idx[k]]           = '0;
                    entry_d[o_alloc_idx[k]].valid     = 1'b1;
                    entry_d[o_alloc_idx[k]].data.info = i_alloc_info[k];
                end else begin
                    entry_d[o_alloc_idx[k]] = entry_d[o_alloc_idx[k]];
                end
            end
            tail_d = tail_q + alloc_cnt_s;
        end else begin
            tail_d = tail_q;
        end
        for (int p = 0; p < UPD_PORTS; p++) begin
            if (i_upd_valid[p] && entry_q[upd_idx_s[p]].valid && !entry_q[upd_idx_s[p]].done &&
                !(rb_valid_s && (upd_age_s[p] > rb_age_s))) begin
                entry_d[upd_idx_s[p]].done              = 1'b1;
                entry_d[upd_idx_s[p]].notify            = ~i_upd_info[p].dead;
                entry_d[upd_idx_s[p]].dead              = i_upd_info[p].dead;
                entry_d[upd_idx_s[p]].data.is_cond      = i_upd_info[p].is_cond;
                entry_d[upd_idx_s[p]].data.taken        = i_upd_info[p].taken;
                entry_d[upd_idx_s[p]].data.mispredict   = i_upd_info[p].mispredict;
                entry_d[upd_idx_s[p]].data.target_vaddr = i_upd_info[p].target_vaddr;
            end else begin
                entry_d[upd_idx_s[p]] = entry_d[upd_idx_s[p]];
            end
        end
        if (rb_valid_s) begin
            tail_d = head_q + {1'b0, rb_age_s} + (IDX_W+1)'(1);
            for (int i = 0; i < DEPTH; i++) begin
                ent_age_s = IDX_W'(i) - head_lo_s;
                if (ent_age_s > rb_age_s) begin
                    entry_d[i].valid = 1'b0;
                end else begin
                    entry_d[i].valid = entry_d[i].valid;
                end
            end
        end else begin
            ent_age_s = '0;
        end
        if (retire_s) begin
            entry_d[head_lo_s].valid = 1'b0;
            head_d = head_q + (IDX_W+1)'(1);
        end else begin
            head_d = head_q;
        end
        if (i_commit_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_d;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule
